// File: rtl/ws_cegen_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
package ws_cegen_pkg;

  // Storage widths for the config shadow; NUM_CH <= 8 and ACC_W <= 32.
  localparam int unsigned CEGEN_CH_MAX_W  = 3;
  localparam int unsigned CEGEN_ACC_MAX_W = 32;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [CEGEN_CH_MAX_W-1:0]  ch;
    logic [CEGEN_ACC_MAX_W-1:0] num;
    logic [CEGEN_ACC_MAX_W-1:0] den;
  } cegen_cfg_t;

  // Settle counter width: must hold LOCK_WAIT-1.
  function automatic int unsigned SETTLE_W(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  // Channel-select width: one bit even for a single channel.
  function automatic int unsigned CH_W(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ws_clk_enable_gen_if.sv
// Runtime ratio configuration bus for ws_clk_enable_gen.
interface ws_clk_enable_gen_if #(
  parameter int unsigned CH_W  = 1,
  parameter int unsigned ACC_W = 24
);
  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_num;
  logic [ACC_W-1:0] cfg_den;
  logic             cfg_busy;
  logic             cfg_err;

  modport master (
    output cfg_wr, cfg_ch, cfg_num, cfg_den,
    input  cfg_busy, cfg_err
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_num, cfg_den,
    output cfg_busy, cfg_err
  );
endinterface

// File: rtl/ws_cegen_chan.sv
// One Bresenham clock-enable channel: accumulator, active ratio, apply
// handshake and registered ce / ce_n outputs.
// Optional half-period enable built only when CEGEN_CE_N_EN is defined.
module ws_cegen_chan
  import ws_cegen_pkg::*;
#(
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned DEF_NUM = 1,
  parameter int unsigned DEF_DEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,       // RUN, locked and channel enabled
  input  logic             clear,      // lock lost: zero the accumulator
  input  logic             apply_req,  // shadow targets this channel
  input  logic [ACC_W-1:0] apply_num,
  input  logic [ACC_W-1:0] apply_den,
  output logic             apply_ack,
  output logic             ce,
  output logic             ce_n
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] num;
  logic [ACC_W-1:0] den;
  logic [ACC_W:0]   s;
  logic             fire;

  assign s    = {1'b0, acc} + {1'b0, num};
  assign fire = (s >= {1'b0, den});

  // A stepping channel takes a new ratio only on its wrap; an idle one at once.
  assign apply_ack = apply_req && (!step || fire);

  // Accumulator step, ratio swap and ce register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      num <= ACC_W'(DEF_NUM);
      den <= ACC_W'(DEF_DEN);
      ce  <= 1'b0;
    end else begin
      ce <= step && fire;
      if (step) begin
        // Wrap uses the outgoing den even on the apply cycle.
        acc <= fire ? ACC_W'(s - {1'b0, den}) : s[ACC_W-1:0];
      end else if (clear || apply_ack) begin
        acc <= '0;
      end
      if (apply_ack) begin
        num <= apply_num;
        den <= apply_den;
      end
    end
  end

`ifdef CEGEN_CE_N_EN
  logic [ACC_W-1:0] half;
  logic             half_ok;
  logic             half_hit;

  assign half     = den >> 1;
  // Midpoint is only unique when at most one step lands per half period.
  assign half_ok  = ({num, 1'b0} <= {1'b0, den});
  assign half_hit = step && half_ok && !fire &&
                    (acc < half) && (s >= {1'b0, half});

  // Half-period enable, same latency as ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_n <= 1'b0;
    end else begin
      ce_n <= half_hit;
    end
  end
`else
  assign ce_n = 1'b0;
`endif

endmodule

// File: rtl/ws_clk_enable_gen.sv
// Multi-channel fractional clock-enable generator with PLL-lock startup
// sequencer and glitch-free runtime ratio reprogramming.
// Define CEGEN_CE_N_EN to build the half-period ce_n outputs.
module ws_clk_enable_gen
  import ws_cegen_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned ACC_W     = 24,
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned DEF_NUM   = 1,
  parameter int unsigned DEF_DEN   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic [NUM_CH-1:0]   ch_en,
  ws_clk_enable_gen_if.slave  cfg,
  output logic [NUM_CH-1:0]   ce,
  output logic [NUM_CH-1:0]   ce_n,
  output logic                ready
);

  localparam int unsigned SW = SETTLE_W(LOCK_WAIT);

  seq_state_t        state;
  logic [SW-1:0]     settle_cnt;
  cegen_cfg_t        shadow;
  logic              busy;
  logic              err;
  logic              cfg_ok;
  logic              cfg_take;
  logic              lost;
  logic [NUM_CH-1:0] step;
  logic [NUM_CH-1:0] apply_req;
  logic [NUM_CH-1:0] apply_ack;
  logic              unused_shadow;

  assign lost = (state != WAIT_LOCK) && !pll_locked;

  // Startup sequencer: wait for lock, settle LOCK_WAIT cycles, then run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      ready      <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (pll_locked) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!pll_locked) begin
            state <= WAIT_LOCK;
          end else if (settle_cnt == SW'(LOCK_WAIT - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        RUN: begin
          if (!pll_locked) begin
            state <= WAIT_LOCK;
            ready <= 1'b0;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ok   = (cfg.cfg_den != '0) && (cfg.cfg_num <= cfg.cfg_den) &&
                    (32'(cfg.cfg_ch) < NUM_CH);
  assign cfg_take = cfg.cfg_wr && !busy && cfg_ok;

  // Config shadow: validate, latch, hold busy until the target channel applies.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      err    <= 1'b0;
      shadow <= '0;
    end else begin
      err <= cfg.cfg_wr && !busy && !cfg_ok;
      if (cfg_take) begin
        busy       <= 1'b1;
        shadow.ch  <= CEGEN_CH_MAX_W'(cfg.cfg_ch);
        shadow.num <= CEGEN_ACC_MAX_W'(cfg.cfg_num);
        shadow.den <= CEGEN_ACC_MAX_W'(cfg.cfg_den);
      end else if (|apply_ack) begin
        busy <= 1'b0;
      end
    end
  end

  assign cfg.cfg_busy = busy;
  assign cfg.cfg_err  = err;

  // Shadow bits above ACC_W are always written as zero.
  assign unused_shadow = ^{shadow.num, shadow.den};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign step[i]      = (state == RUN) && pll_locked && ch_en[i];
    assign apply_req[i] = busy && (shadow.ch == CEGEN_CH_MAX_W'(i));

    ws_cegen_chan #(
      .ACC_W   (ACC_W),
      .DEF_NUM (DEF_NUM),
      .DEF_DEN (DEF_DEN)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .step      (step[i]),
      .clear     (lost),
      .apply_req (apply_req[i]),
      .apply_num (shadow.num[ACC_W-1:0]),
      .apply_den (shadow.den[ACC_W-1:0]),
      .apply_ack (apply_ack[i]),
      .ce        (ce[i]),
      .ce_n      (ce_n[i])
    );
  end

endmodule

// File: tb/tb_ws_clk_enable_gen.sv
// Bench for ws_clk_enable_gen: startup timing, ratio accuracy, runtime
// reprogramming, config rejection, lock loss, reset and (with
// CEGEN_CE_N_EN) half-period enables.
`timescale 1ns/1ps
module tb_ws_clk_enable_gen;
  import ws_cegen_pkg::*;

  localparam int unsigned NUM_CH    = 2;
  localparam int unsigned ACC_W     = 24;
  localparam int unsigned LOCK_WAIT = 16;
  localparam int unsigned CHW       = CH_W(NUM_CH);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pll_locked = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic [NUM_CH-1:0] ce;
  logic [NUM_CH-1:0] ce_n;
  logic              ready;

  ws_clk_enable_gen_if #(.CH_W(CHW), .ACC_W(ACC_W)) cfg_if ();

  ws_clk_enable_gen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_WAIT(LOCK_WAIT), .DEF_NUM(1), .DEF_DEN(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .ch_en      (ch_en),
    .cfg        (cfg_if.slave),
    .ce         (ce),
    .ce_n       (ce_n),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic             wr;
    logic [CHW-1:0]   ch;
    logic [ACC_W-1:0] num;
    logic [ACC_W-1:0] den;
    logic             exp_err;
    logic             exp_busy;
  } vec_t;

  typedef struct {
    int   idx;
    logic err;
    logic busy;
  } exp_t;

  vec_t vt[6];
  exp_t sb[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_drive(input logic wr, input logic [CHW-1:0] ch,
                           input logic [ACC_W-1:0] num, input logic [ACC_W-1:0] den);
    cfg_if.cfg_wr  = wr;
    cfg_if.cfg_ch  = ch;
    cfg_if.cfg_num = num;
    cfg_if.cfg_den = den;
  endtask

  // Count edges from pll_locked rising until ready; ce must stay quiet.
  task automatic wait_ready(input string name);
    int n = 0;
    int ce_seen = 0;
    while (!ready && n < 200) begin
      tick;
      n++;
      if (ce != '0) ce_seen++;
    end
    chk({name, " ready_latency"}, n, LOCK_WAIT + 1);
    chk({name, " no_ce_before_ready"}, ce_seen, 0);
  endtask

  // Wait for cfg_busy to drop; the target's ce must be high on that cycle.
  task automatic wait_apply(input string name, input int ch);
    int n = 0;
    while (cfg_if.cfg_busy && n < 20) begin
      tick;
      n++;
    end
    chk({name, " busy_drop"}, cfg_if.cfg_busy, 0);
    chk({name, " ce_at_apply"}, ce[ch], 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0, cnt1, cntn, last, bad, prev, prev1, prev2;
    exp_t e;

    vt[0] = '{1'b1, 1'b0, 24'd0, 24'd0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 24'd6, 24'd5, 1'b1, 1'b0};
    vt[3] = '{1'b0, 1'b0, 24'd0, 24'd0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 24'd3, 24'd0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 24'd8, 24'd7, 1'b1, 1'b0};

    cfg_drive(1'b0, '0, '0, '0);
    ch_en = 2'b11;

    // Reset state
    repeat (3) tick;
    chk("rst ce", ce, 0);
    chk("rst ce_n", ce_n, 0);
    chk("rst ready", ready, 0);
    chk("rst busy", cfg_if.cfg_busy, 0);
    chk("rst err", cfg_if.cfg_err, 0);
    rst = 1'b0;
    repeat (2) tick;
    chk("prelock ready", ready, 0);

    // Startup: LOCK_WAIT settle after lock
    pll_locked = 1'b1;
    wait_ready("t1");

    // Default 1/3 on ch0: 100 pulses in 300 cycles, spaced 3
    cnt0 = 0; last = -1; bad = 0;
    for (int i = 1; i <= 300; i++) begin
      tick;
      if (ce[0]) begin
        if (last >= 0 && i - last != 3) bad++;
        last = i;
        cnt0++;
      end
    end
    chk("t2 ce0_count", cnt0, 100);
    chk("t2 ce0_spacing_errs", bad, 0);

    // Disabled channel stays silent
    ch_en = 2'b10;
    cnt0 = 0;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (ce[0]) cnt0++;
    end
    chk("freeze ce0_count", cnt0, 0);
    ch_en = 2'b11;
    tick;

    // Reprogram ch1 to 2/5 mid-period; a write while busy is ignored
    cfg_drive(1'b1, 1'b1, 24'd2, 24'd5);
    tick;
    chk("t3 busy_after_wr", cfg_if.cfg_busy, 1);
    chk("t3 err_after_wr", cfg_if.cfg_err, 0);
    cfg_drive(1'b1, 1'b0, 24'd0, 24'd0);
    tick;
    cfg_drive(1'b0, '0, '0, '0);
    chk("t3 wr_while_busy_err", cfg_if.cfg_err, 0);
    wait_apply("t3", 1);
    cnt1 = 0; bad = 0; prev = 1;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (ce[1]) cnt1++;
      if (ce[1] && prev) bad++;
      prev = ce[1];
    end
    chk("t3 ce1_count_100", cnt1, 40);
    chk("t3 ce1_double_pulse", bad, 0);

    // Rejected writes: table-driven, expectations queued at drive time
    for (int i = 0; i < 6; i++) begin
      cfg_drive(vt[i].wr, vt[i].ch, vt[i].num, vt[i].den);
      sb.push_back('{i, vt[i].exp_err, vt[i].exp_busy});
      tick;
      e = sb.pop_front();
      chk($sformatf("t4 vec%0d err", e.idx), cfg_if.cfg_err, e.err);
      chk($sformatf("t4 vec%0d busy", e.idx), cfg_if.cfg_busy, e.busy);
    end
    cfg_drive(1'b0, '0, '0, '0);
    tick;
    chk("t4 err_clears", cfg_if.cfg_err, 0);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (ce[0]) cnt0++;
      if (ce[1]) cnt1++;
    end
    chk("t4 ce0_unchanged", cnt0, 20);
    chk("t4 ce1_unchanged", cnt1, 24);

    // Lock loss during RUN, then full settle on relock
    pll_locked = 1'b0;
    tick;
    chk("t5 ready_drop", ready, 0);
    chk("t5 ce_drop", ce, 0);
    cnt0 = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (ce != '0 || ready) cnt0++;
    end
    chk("t5 quiet_unlocked", cnt0, 0);
    pll_locked = 1'b1;
    wait_ready("t5");
    tick;
    chk("t5 acc_cleared_step1", ce[0], 0);
    tick;
    chk("t5 acc_cleared_step2", ce[0], 0);
    tick;
    chk("t5 acc_cleared_step3", ce[0], 1);

    // ch0 -> 1/4: ce_n two cycles after each ce (when built)
    cfg_drive(1'b1, 1'b0, 24'd1, 24'd4);
    tick;
    cfg_drive(1'b0, '0, '0, '0);
    wait_apply("t6a", 0);
    cnt0 = 0; cntn = 0; bad = 0; prev1 = 1; prev2 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick;
      if (ce[0]) cnt0++;
      if (ce_n[0]) cntn++;
      if (ce_n[0] != prev2[0]) bad++;
      prev2 = prev1;
      prev1 = ce[0];
    end
    chk("t6 ce0_count_1_4", cnt0, 10);
`ifdef CEGEN_CE_N_EN
    chk("t6 ce_n_count_1_4", cntn, 10);
    chk("t6 ce_n_offset_errs", bad, 0);
`else
    chk("t6 ce_n_tied_low", cntn, 0);
`endif

    // ch0 -> 3/4: ce_n held low
    cfg_drive(1'b1, 1'b0, 24'd3, 24'd4);
    tick;
    cfg_drive(1'b0, '0, '0, '0);
    wait_apply("t6b", 0);
    cnt0 = 0; cntn = 0;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (ce[0]) cnt0++;
      if (ce_n[0]) cntn++;
    end
    chk("t6 ce0_count_3_4", cnt0, 30);
    chk("t6 ce_n_count_3_4", cntn, 0);

    // Reset mid-operation discards a pending write and restores defaults
    cfg_drive(1'b1, 1'b1, 24'd1, 24'd2);
    tick;
    cfg_drive(1'b0, '0, '0, '0);
    chk("t7 busy_pending", cfg_if.cfg_busy, 1);
    rst = 1'b1;
    tick;
    chk("t7 rst_busy", cfg_if.cfg_busy, 0);
    chk("t7 rst_ready", ready, 0);
    chk("t7 rst_ce", ce, 0);
    rst = 1'b0;
    wait_ready("t7");
    cnt1 = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (ce[1]) cnt1++;
    end
    chk("t7 ce1_default_ratio", cnt1, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
